// File: rtl/sim_clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sim_clock_pkg
// Description : Shared types and constants for the derived-clock sequencer:
//               sequencer state encoding and per-channel configuration record.
// Revision    : 1.0 - initial release
// ============================================================================
package sim_clock_pkg;

    // Default width of the half-period / phase counters; also the storage
    // width of the configuration record below.
    localparam int c_div_w = 16;

    // Sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // One channel's configuration as held in the register file.
    typedef struct packed {
        logic               en;
        logic [c_div_w-1:0] half;
        logic [c_div_w-1:0] phase;
    } chan_cfg_t;

endpackage
`default_nettype wire

// File: rtl/sim_clock_channel.sv
`default_nettype none
// ============================================================================
// Module      : sim_clock_channel
// Description : One derived clock. Preloads phase+half on LOAD, toggles every
//               half cycles in RUN, and in DRAIN only lets a high clock finish
//               its falling toggle before freezing low.
// Revision    : 1.0 - initial release
// ============================================================================
module sim_clock_channel #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic             drain,
    input  logic             en,
    input  logic [DIV_W-1:0] half,
    input  logic [DIV_W-1:0] phase,
    output logic             clk_out,
    output logic             tick,
    output logic             frozen
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_clk;
    logic             r_tick;
    logic [DIV_W-1:0] w_hm1;
    logic [DIV_W:0]   w_sum;
    logic [DIV_W-1:0] w_load_val;

    // Reload value max(half,1)-1 and the saturating first-rise preload.
    always_comb begin
        w_hm1      = (half == '0) ? '0 : (half - 1'b1);
        w_sum      = {1'b0, phase} + {1'b0, w_hm1};
        w_load_val = w_sum[DIV_W] ? '1 : w_sum[DIV_W-1:0];
    end

    // Counter / toggle / tick. A low clock in DRAIN is simply not advanced,
    // so no rising edge can be produced once stopping has begun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (load) begin
                r_cnt <= w_load_val;
                r_clk <= 1'b0;
            end else if ((run && en) || (drain && r_clk)) begin
                if (r_cnt == '0) begin
                    r_clk  <= ~r_clk;
                    r_cnt  <= w_hm1;
                    r_tick <= run && !r_clk;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign clk_out = r_clk;
    assign tick    = r_tick;
    assign frozen  = ~r_clk;

endmodule
`default_nettype wire

// File: rtl/sim_clock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sim_clock_sequencer
// Description : Generates N_CLK derived clocks from sys_clk. Holds the
//               channel configuration registers and the IDLE/LOAD/RUN/DRAIN
//               start-stop sequencer; channels start phase-aligned and stop
//               glitch-free in their low state.
// Revision    : 1.0 - initial release
// ============================================================================
module sim_clock_sequencer
    import sim_clock_pkg::*;
#(
    parameter int N_CLK = 4,
    parameter int DIV_W = c_div_w,
    parameter int IDX_W = (N_CLK > 1) ? $clog2(N_CLK) : 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             cfg_en,
    input  logic [DIV_W-1:0] cfg_half,
    input  logic [DIV_W-1:0] cfg_phase,
    input  logic             start,
    input  logic             stop,
    output logic             running,
    output logic             done,
    output logic [N_CLK-1:0] clk_out,
    output logic [N_CLK-1:0] tick
);

    // The configuration record is stored at package width (DIV_W must not
    // exceed it); values are zero-extended on write and truncated on read.
    chan_cfg_t        r_cfg [N_CLK];
    state_t           r_state;
    state_t           w_next;
    logic             r_done;
    logic             w_load;
    logic             w_run;
    logic             w_drain;
    logic [N_CLK-1:0] w_frozen;
    logic             w_all_frozen;

    assign w_all_frozen = &w_frozen;

    // Sequencer state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE, stop only in RUN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)        w_next = LOAD;
            LOAD:                      w_next = RUN;
            RUN:     if (stop)         w_next = DRAIN;
            DRAIN:   if (w_all_frozen) w_next = IDLE;
            default:                   w_next = IDLE;
        endcase
    end

    // State decode for the channels and the status outputs.
    always_comb begin
        w_load    = (r_state == LOAD);
        w_run     = (r_state == RUN);
        w_drain   = (r_state == DRAIN);
        running   = (r_state != IDLE);
        cfg_ready = (r_state == IDLE);
    end

    // done pulses for the single cycle following the DRAIN->IDLE edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == DRAIN) && w_all_frozen;
        end
    end

    assign done = r_done;

    // Config register file; writes only in IDLE, out-of-range indices match
    // no channel and are dropped.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < N_CLK; i++) begin
                r_cfg[i] <= '{en: 1'b0, half: c_div_w'(1), phase: '0};
            end
        end else if ((r_state == IDLE) && cfg_valid) begin
            for (int i = 0; i < N_CLK; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    r_cfg[i] <= '{en: cfg_en, half: c_div_w'(cfg_half), phase: c_div_w'(cfg_phase)};
                end
            end
        end
    end

    for (genvar g = 0; g < N_CLK; g++) begin : g_chan
        sim_clock_channel #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk     (sys_clk),
            .rst     (sys_rst),
            .load    (w_load),
            .run     (w_run),
            .drain   (w_drain),
            .en      (r_cfg[g].en),
            .half    (DIV_W'(r_cfg[g].half)),
            .phase   (DIV_W'(r_cfg[g].phase)),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .frozen  (w_frozen[g])
        );
    end

endmodule
`default_nettype wire
